// File: rtl/mips_debug_unit.sv
// mips_debug_unit: UART-side debug endpoint that loads program memory, gates the MIPS pipeline and dumps processor state.
// Ports: i_clk/i_rst (sync, active-low) | i_rx_data/i_rx_valid command bytes in |
//   o_tx_data/o_tx_start/i_tx_done byte handshake out | o_prog_we/o_prog_addr/o_prog_data program writes |
//   o_cpu_en/i_halt/i_pc pipeline control | o_reg_addr/i_reg_data, o_mem_addr/i_mem_data state readback | o_busy
module mips_debug_unit #(
  parameter int LEN = 32,
  parameter int NB_PADDR = 11,
  parameter int NB_DADDR = 10,
  parameter int NB_RADDR = 5,
  parameter int N_DATA_DUMP = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_valid,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_start,
  input  logic                i_tx_done,
  output logic                o_prog_we,
  output logic [NB_PADDR-1:0] o_prog_addr,
  output logic [LEN-1:0]      o_prog_data,
  output logic                o_cpu_en,
  input  logic                i_halt,
  input  logic [LEN-1:0]      i_pc,
  output logic [NB_RADDR-1:0] o_reg_addr,
  input  logic [LEN-1:0]      i_reg_data,
  output logic [NB_DADDR-1:0] o_mem_addr,
  input  logic [LEN-1:0]      i_mem_data,
  output logic                o_busy
);
  localparam int NI = 33 + N_DATA_DUMP;
  localparam int IW = $clog2(NI);
  typedef enum logic [3:0] {
    IDLE, LD_CNT_LO, LD_CNT_HI, LD_WORD, RUN, STEP, SETTLE, DUMP_LOAD, DUMP_SEND, DUMP_WAIT
  } state_t;
  state_t state, nxt;
  logic [15:0]         cnt;
  logic [NB_PADDR-1:0] widx;
  logic [1:0]          bcnt;
  logic [IW-1:0]       item;
  logic [LEN-1:0]      asm_w;
  logic [LEN-1:0]      sreg;
  logic                last_item;
  assign last_item = item == IW'(NI - 1);
  assign o_tx_data = sreg[LEN-1 -: 8];
  always_ff @(posedge i_clk) begin
    if (!i_rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (i_rx_valid)
        nxt = i_rx_data == 8'h4C ? LD_CNT_LO :
              i_rx_data == 8'h52 ? RUN :
              i_rx_data == 8'h53 ? STEP :
              i_rx_data == 8'h44 ? DUMP_LOAD : IDLE;
      LD_CNT_LO: if (i_rx_valid) nxt = LD_CNT_HI;
      LD_CNT_HI: if (i_rx_valid) nxt = {i_rx_data, cnt[7:0]} == 16'd0 ? IDLE : LD_WORD;
      LD_WORD:   if (i_rx_valid && bcnt == 2'd3 && cnt == 16'd1) nxt = IDLE;
      RUN:       if (i_halt) nxt = SETTLE;
      STEP:      nxt = SETTLE;
      SETTLE:    nxt = DUMP_LOAD;
      DUMP_LOAD: nxt = DUMP_SEND;
      DUMP_SEND: nxt = DUMP_WAIT;
      DUMP_WAIT: if (i_tx_done) nxt = bcnt != 2'd3 ? DUMP_SEND : last_item ? IDLE : DUMP_LOAD;
      default:   nxt = IDLE;
    endcase
  end
  always_comb begin
    o_cpu_en   = state == STEP || (state == RUN && !i_halt);
    o_tx_start = state == DUMP_SEND;
    o_busy     = state != IDLE;
    // item 0 is the PC, items 1..32 the registers, the rest data memory
    o_reg_addr = (item != '0 && item <= IW'(32)) ? NB_RADDR'(item - IW'(1)) : '0;
    o_mem_addr = item > IW'(32) ? NB_DADDR'(item - IW'(33)) : '0;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt         <= '0;
      widx        <= '0;
      bcnt        <= '0;
      item        <= '0;
      asm_w       <= '0;
      sreg        <= '0;
      o_prog_we   <= 1'b0;
      o_prog_addr <= '0;
      o_prog_data <= '0;
    end else begin
      o_prog_we <= 1'b0;
      case (state)
        IDLE: begin
          widx <= '0;
          bcnt <= '0;
          item <= '0;
        end
        LD_CNT_LO: if (i_rx_valid) cnt <= {8'h00, i_rx_data};
        LD_CNT_HI: if (i_rx_valid) cnt[15:8] <= i_rx_data;
        LD_WORD: if (i_rx_valid) begin
          asm_w <= {asm_w[LEN-9:0], i_rx_data};
          bcnt  <= bcnt + 2'd1;
          if (bcnt == 2'd3) begin
            o_prog_we   <= 1'b1;
            o_prog_addr <= widx;
            o_prog_data <= {asm_w[LEN-9:0], i_rx_data};
            widx        <= widx + NB_PADDR'(1);
            cnt         <= cnt - 16'd1;
          end
        end
        DUMP_LOAD: sreg <= item == '0 ? i_pc : item <= IW'(32) ? i_reg_data : i_mem_data;
        DUMP_WAIT: if (i_tx_done) begin
          sreg <= sreg << 8;
          bcnt <= bcnt + 2'd1;
          if (bcnt == 2'd3) item <= item + IW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_debug_unit.sv
// tb_mips_debug_unit: scoreboard bench for mips_debug_unit driving directed command sequences.
module tb_mips_debug_unit;
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        i_tx_done;
  logic        o_prog_we;
  logic [10:0] o_prog_addr;
  logic [31:0] o_prog_data;
  logic        o_cpu_en;
  logic        i_halt;
  logic [31:0] i_pc;
  logic [4:0]  o_reg_addr;
  logic [31:0] i_reg_data;
  logic [9:0]  o_mem_addr;
  logic [31:0] i_mem_data;
  logic        o_busy;
  int checks = 0, errors = 0;
  logic [7:0]  exp_tx[$], got_tx[$];
  logic [42:0] exp_wr[$], got_wr[$];
  int tx_i = 0, wr_i = 0, en_cnt = 0;
  bit pend = 1'b0;
  logic [7:0] held = 8'h00;
  int stray_req = 0, stray_ack = 0;
  int max_dly = 4;
  mips_debug_unit dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
    .o_prog_we(o_prog_we), .o_prog_addr(o_prog_addr), .o_prog_data(o_prog_data),
    .o_cpu_en(o_cpu_en), .i_halt(i_halt), .i_pc(i_pc),
    .o_reg_addr(o_reg_addr), .i_reg_data(i_reg_data),
    .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data), .o_busy(o_busy)
  );
  always #5 i_clk = ~i_clk;
  function automatic logic [31:0] reg_word(input int i);
    return 32'hDEAD0000 | (32'(i) << 8) | 32'(i);
  endfunction
  function automatic logic [31:0] mem_word(input int i);
    return 32'h5A000000 | (32'(i) << 16) | 32'(i);
  endfunction
  assign i_reg_data = reg_word(int'(o_reg_addr));
  assign i_mem_data = mem_word(int'(o_mem_addr));
  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  task automatic push_dump();
    logic [31:0] w;
    for (int k = 0; k < 49; k++) begin
      w = k == 0 ? i_pc : k <= 32 ? reg_word(k - 1) : mem_word(k - 33);
      for (int b = 3; b >= 0; b--) exp_tx.push_back(w[8*b +: 8]);
    end
  endtask
  task automatic send(input logic [7:0] b);
    i_rx_data = b;
    i_rx_valid = 1'b1;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
  endtask
  task automatic wait_idle(input int budget);
    int n = 0;
    while (o_busy && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    chk(!o_busy, "idle_timeout", n, budget);
    repeat (2) @(negedge i_clk);
  endtask
  initial begin
    i_tx_done = 1'b0;
    forever begin
      @(negedge i_clk);
      i_tx_done = 1'b0;
      if (o_tx_start) begin
        repeat ($urandom_range(1, max_dly)) @(negedge i_clk);
        i_tx_done = 1'b1;
      end else if (stray_req != stray_ack) begin
        stray_ack++;
        i_tx_done = 1'b1;
      end
    end
  end
  always @(negedge i_clk) begin
    #1;
    if (o_cpu_en === 1'b1) en_cnt++;
    if (o_prog_we === 1'b1) begin
      got_wr.push_back({o_prog_addr, o_prog_data});
      chk(wr_i < exp_wr.size(), "prog_we_count", wr_i + 1, exp_wr.size());
      if (wr_i < exp_wr.size()) begin
        chk(o_prog_addr == exp_wr[wr_i][42:32], "prog_addr", 32'(o_prog_addr), 32'(exp_wr[wr_i][42:32]));
        chk(o_prog_data == exp_wr[wr_i][31:0], "prog_data", o_prog_data, exp_wr[wr_i][31:0]);
      end
      wr_i++;
    end
    if (pend) chk(o_tx_data == held, "tx_data_stable", 32'(o_tx_data), 32'(held));
    if (i_tx_done === 1'b1) pend = 1'b0;
    if (o_tx_start === 1'b1) begin
      chk(!pend, "tx_start_while_pending", 1, 0);
      got_tx.push_back(o_tx_data);
      chk(tx_i < exp_tx.size(), "tx_byte_count", tx_i + 1, exp_tx.size());
      if (tx_i < exp_tx.size()) chk(o_tx_data == exp_tx[tx_i], "tx_byte", 32'(o_tx_data), 32'(exp_tx[tx_i]));
      tx_i++;
      pend = 1'b1;
      held = o_tx_data;
    end
  end
  initial begin
    int base, e0;
    i_rst = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_data = 8'h00;
    i_halt = 1'b0;
    i_pc = 32'h0;
    repeat (3) @(negedge i_clk);
    chk(o_tx_data == 8'h00, "rst_tx_data", 32'(o_tx_data), 0);
    chk(o_tx_start == 1'b0, "rst_tx_start", 32'(o_tx_start), 0);
    chk(o_prog_we == 1'b0, "rst_prog_we", 32'(o_prog_we), 0);
    chk(o_prog_addr == 11'd0, "rst_prog_addr", 32'(o_prog_addr), 0);
    chk(o_prog_data == 32'd0, "rst_prog_data", o_prog_data, 0);
    chk(o_cpu_en == 1'b0, "rst_cpu_en", 32'(o_cpu_en), 0);
    chk(o_reg_addr == 5'd0, "rst_reg_addr", 32'(o_reg_addr), 0);
    chk(o_mem_addr == 10'd0, "rst_mem_addr", 32'(o_mem_addr), 0);
    chk(o_busy == 1'b0, "rst_busy", 32'(o_busy), 0);
    i_rst = 1'b1;
    @(negedge i_clk);
    send(8'h4C); send(8'h02); send(8'h00); send(8'h11); send(8'h22);
    i_rst = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    chk(o_busy == 1'b0, "busy_after_midload_reset", 32'(o_busy), 0);
    exp_wr.push_back({11'd0, 32'hAABBCCDD});
    send(8'h4C); send(8'h01); send(8'h00);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    wait_idle(20);
    chk(wr_i == exp_wr.size(), "reload_write_count", wr_i, exp_wr.size());
    chk(got_wr[0][31:0] == 32'hAABBCCDD, "reload_word", got_wr[0][31:0], 32'hAABBCCDD);
    exp_wr.push_back({11'd0, 32'h20010005});
    exp_wr.push_back({11'd1, 32'h0000003F});
    send(8'h4C);
    chk(o_busy == 1'b1, "busy_after_cmd", 32'(o_busy), 1);
    send(8'h02); send(8'h00);
    send(8'h20); send(8'h01); send(8'h00); send(8'h05);
    send(8'h00); send(8'h00); send(8'h00); send(8'h3F);
    wait_idle(20);
    chk(wr_i == 3, "load_write_count", wr_i, 3);
    chk(got_wr[1] == {11'd0, 32'h20010005}, "load_word0", got_wr[1][31:0], 32'h20010005);
    chk(got_wr[2] == {11'd1, 32'h0000003F}, "load_word1", got_wr[2][31:0], 32'h0000003F);
    chk(o_busy == 1'b0, "busy_after_load", 32'(o_busy), 0);
    send(8'h7E);
    repeat (3) @(negedge i_clk);
    chk(o_busy == 1'b0, "ignored_byte_busy", 32'(o_busy), 0);
    stray_req++;
    repeat (6) @(negedge i_clk);
    chk(tx_i == 0, "stray_done_tx", tx_i, 0);
    chk(o_busy == 1'b0, "stray_done_busy", 32'(o_busy), 0);
    i_pc = 32'h4;
    max_dly = 50;
    base = exp_tx.size();
    push_dump();
    e0 = en_cnt;
    send(8'h53);
    wait_idle(12000);
    chk(en_cnt - e0 == 1, "step_en_cycles", en_cnt - e0, 1);
    chk(got_tx.size() - base == 196, "step_dump_len", got_tx.size() - base, 196);
    chk({got_tx[base], got_tx[base+1], got_tx[base+2], got_tx[base+3]} == 32'h00000004, "step_pc_bytes",
        {got_tx[base], got_tx[base+1], got_tx[base+2], got_tx[base+3]}, 32'h00000004);
    chk({got_tx[base+4], got_tx[base+5], got_tx[base+6], got_tx[base+7]} == 32'hDEAD0000, "step_reg0_bytes",
        {got_tx[base+4], got_tx[base+5], got_tx[base+6], got_tx[base+7]}, 32'hDEAD0000);
    chk(got_tx[base+131] == 8'h1F, "step_reg31_lsb", 32'(got_tx[base+131]), 32'h1F);
    chk(got_tx[base+195] == 8'h0F, "step_mem15_lsb", 32'(got_tx[base+195]), 32'h0F);
    i_pc = 32'h100;
    max_dly = 3;
    base = exp_tx.size();
    push_dump();
    e0 = en_cnt;
    send(8'h52);
    repeat (3) @(negedge i_clk);
    send(8'h44);
    repeat (6) @(negedge i_clk);
    i_halt = 1'b1;
    repeat (20) @(negedge i_clk);
    send(8'h53);
    send(8'h4C);
    wait_idle(3000);
    chk(en_cnt - e0 == 10, "run_en_cycles", en_cnt - e0, 10);
    chk(got_tx.size() - base == 196, "run_dump_len", got_tx.size() - base, 196);
    chk(got_tx[base+2] == 8'h01, "run_pc_byte", 32'(got_tx[base+2]), 32'h01);
    i_pc = 32'h200;
    base = exp_tx.size();
    push_dump();
    e0 = en_cnt;
    send(8'h52);
    wait_idle(3000);
    chk(en_cnt - e0 == 0, "run_halted_en_cycles", en_cnt - e0, 0);
    chk(got_tx.size() - base == 196, "run_halted_dump_len", got_tx.size() - base, 196);
    chk(got_tx[base+2] == 8'h02, "run_halted_pc_byte", 32'(got_tx[base+2]), 32'h02);
    i_halt = 1'b0;
    i_pc = 32'hCAFEBABE;
    base = exp_tx.size();
    push_dump();
    e0 = en_cnt;
    send(8'h44);
    wait_idle(3000);
    chk(en_cnt - e0 == 0, "dump_en_cycles", en_cnt - e0, 0);
    chk(got_tx[base] == 8'hCA, "dump_pc_msb", 32'(got_tx[base]), 32'hCA);
    chk(tx_i == exp_tx.size(), "total_tx_bytes", tx_i, exp_tx.size());
    chk(wr_i == exp_wr.size(), "total_writes", wr_i, exp_wr.size());
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
